// File: rtl/bus_xfer_sequencer_pkg.sv
// bus_xfer_sequencer_pkg: shared state encoding, direction constants and default widths
package bus_xfer_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    LATCH = 3'd2,
    INC   = 3'd3,
    TURN  = 3'd4
  } state_t;
  localparam logic RW_DRIVE = 1'b1;
  localparam logic RW_LOAD = 1'b0;
  localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/bus_xfer_sequencer_sel_decode.sv
// bus_sel_decode: enabled one-hot decoder from a register select to per-register lines
module bus_sel_decode
  import bus_xfer_sequencer_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  output logic [NUM_REGS-1:0] onehot
);
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
    assign onehot[i] = en && int'(sel) == i;
  end
endmodule

// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: sequences register-to-register bus transfers with single-driver ownership
module bus_xfer_sequencer
  import bus_xfer_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int SEL_W = 3,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic [SEL_W-1:0]    CMD_SRC,
  input  logic [SEL_W-1:0]    CMD_DST,
  input  logic                CMD_EXT,
  input  logic                CMD_INC,
  input  logic [DATA_W-1:0]   DATA_EXT,
  inout  wire  [DATA_W-1:0]   DATA,
  output logic                EXT_OE,
  output logic [NUM_REGS-1:0] REG_ENABLE,
  output logic [NUM_REGS-1:0] REG_RW,
  output logic [NUM_REGS-1:0] REG_COUNT,
  output logic                BUSY,
  output logic [DATA_W-1:0]   LAST_DATA,
  output logic                ERR
);
  state_t state, state_nxt;
  logic [SEL_W-1:0] src_q, dst_q, n_src, n_dst;
  logic ext_q, inc_q, n_ext, accept, bad, src_act, dst_act;
  logic [DATA_W-1:0] data_q;
  logic [NUM_REGS-1:0] src_oh, dst_oh, rw_nxt;

  assign CMD_READY = state == IDLE && !RESET;
  assign accept = CMD_VALID && CMD_READY;
  assign bad = int'(CMD_DST) >= NUM_REGS || (!CMD_EXT && (int'(CMD_SRC) >= NUM_REGS || CMD_SRC == CMD_DST));
  assign BUSY = state != IDLE;
  assign DATA = EXT_OE ? data_q : 'z;

  // Strobes are decoded from the upcoming state, so on accept the fresh command fields are used
  assign n_src = accept ? CMD_SRC : src_q;
  assign n_dst = accept ? CMD_DST : dst_q;
  assign n_ext = accept ? CMD_EXT : ext_q;
  assign src_act = !n_ext && (state_nxt == DRIVE || state_nxt == LATCH);
  assign dst_act = state_nxt == LATCH || state_nxt == INC;

  bus_sel_decode #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_src (.en(src_act), .sel(n_src), .onehot(src_oh));
  bus_sel_decode #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dst (.en(dst_act), .sel(n_dst), .onehot(dst_oh));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_rw
    assign rw_nxt[i] = src_oh[i] ? RW_DRIVE : RW_LOAD;
  end

  // Transfer sequence: drive, latch, optional increment, then one turnaround cycle
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept && !bad ? DRIVE : IDLE;
      DRIVE:   state_nxt = LATCH;
      LATCH:   state_nxt = inc_q ? INC : TURN;
      INC:     state_nxt = TURN;
      default: state_nxt = IDLE;
    endcase
  end

  // State, held command fields, reject pulse and debug capture of the latched bus word
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      ext_q <= 1'b0;
      inc_q <= 1'b0;
      data_q <= '0;
      ERR <= 1'b0;
      LAST_DATA <= '0;
    end else begin
      state <= state_nxt;
      ERR <= accept && bad;
      if (state == LATCH) LAST_DATA <= DATA;
      if (accept && !bad) begin
        src_q <= CMD_SRC;
        dst_q <= CMD_DST;
        ext_q <= CMD_EXT;
        inc_q <= CMD_INC;
        data_q <= DATA_EXT;
      end
    end
  end

  // Registered strobes so register enables and bus direction change glitch-free
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      REG_ENABLE <= '0;
      REG_RW <= '0;
      REG_COUNT <= '0;
      EXT_OE <= 1'b0;
    end else begin
      REG_ENABLE <= src_oh | dst_oh;
      REG_RW <= rw_nxt;
      REG_COUNT <= state_nxt == INC ? dst_oh : '0;
      EXT_OE <= n_ext && (state_nxt == DRIVE || state_nxt == LATCH);
    end
  end
endmodule
